// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_pkg
// Description : Shared types and defaults for the RV32I core front end.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

  // Architectural register / address width.
  localparam int XLEN = 32;

  // Default first fetch address after reset.
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Default instruction memory word-address width (4096 words = 16 KiB).
  localparam int IMEM_AW_DEFAULT = 12;

  // Fetch-stage control states. FAULT is only reachable when the
  // misaligned-redirect trap is compiled in.
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  // Sequential next-PC: one 32-bit instruction ahead, wrapping at 2^32.
  function automatic logic [XLEN-1:0] pc_next_seq(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch
// Description : RV32I instruction-fetch stage. Owns the program counter,
//               drives a synchronous instruction memory (1-cycle read
//               latency, output held while enable is low) and hands fetched
//               words to decode over a valid/ready handshake. Accepts
//               redirects from execute and halt requests from control.
// Options     : IF_FETCH_MISALIGN_TRAP_EN - when defined, a redirect to a
//               non word-aligned target issues nothing and parks the stage
//               in FAULT (fetch_fault/fault_pc) until an aligned redirect.
//               When undefined, the low two target bits are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              IMEM_AW  = IMEM_AW_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  // Instruction memory port
  output logic               o_imem_en,
  output logic [3:0]         o_imem_we,
  output logic [XLEN-1:0]    o_imem_wdata,
  output logic [IMEM_AW-1:0] o_imem_adr,
  input  logic [XLEN-1:0]    i_imem_rdata,
  // Control inputs
  input  logic               i_redirect_valid,
  input  logic [XLEN-1:0]    i_redirect_pc,
  input  logic               i_halt_req,
  // Decode handshake
  output logic               o_id_valid,
  input  logic               i_id_ready,
  output logic [XLEN-1:0]    o_id_inst,
  output logic [XLEN-1:0]    o_id_pc,
  // Misaligned-redirect trap
  output logic               o_fetch_fault,
  output logic [XLEN-1:0]    o_fault_pc
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] r_pc_q;       // next sequential fetch address
  logic [XLEN-1:0] r_inst_pc_q;  // PC of the word in flight / held at decode
  logic            r_valid_q;    // memory output holds an undelivered word
  fetch_state_t    r_state_q;

  fetch_state_t    w_state_d;
  logic            w_issue;      // a fetch is issued this cycle
  logic            w_misalign;   // redirect target is trapped as misaligned
  logic [XLEN-1:0] w_tgt;        // redirect target after alignment policy
  logic [XLEN-1:0] w_fa;         // fetch address for this cycle

  // --------------------------------------------------------------------------
  // Redirect target policy
  // --------------------------------------------------------------------------
`ifdef IF_FETCH_MISALIGN_TRAP_EN
  assign w_tgt      = i_redirect_pc;
  assign w_misalign = i_redirect_valid & (i_redirect_pc[1:0] != 2'b00);
`else
  // Without the trap the byte offset is simply dropped, so a target of
  // 0x102 fetches the word at 0x100.
  logic w_unused_lsb;
  assign w_unused_lsb = ^i_redirect_pc[1:0];
  assign w_tgt        = {i_redirect_pc[XLEN-1:2], 2'b00};
  assign w_misalign   = 1'b0;
`endif

  // A redirect takes effect in its own cycle, so the target is issued
  // immediately and only one bubble is paid.
  assign w_fa       = i_redirect_valid ? w_tgt : r_pc_q;
  assign o_imem_adr = w_fa[IMEM_AW+1:2];

  // The fetch port never writes.
  assign o_imem_we    = 4'b0000;
  assign o_imem_wdata = '0;
  assign o_imem_en    = w_issue;

  // --------------------------------------------------------------------------
  // Next-state and issue decision
  // --------------------------------------------------------------------------
  // Decide whether to issue a fetch and where the control FSM goes next.
  always_comb begin
    w_state_d = r_state_q;
    w_issue   = 1'b0;
    case (r_state_q)
      BOOT: begin
        // One quiet cycle after reset before the first fetch.
        w_state_d = RUN;
      end
      RUN: begin
        if (i_redirect_valid) begin
          // Redirect beats halt when both arrive together.
          if (w_misalign) begin
            w_state_d = FAULT;
          end else begin
            w_issue = 1'b1;
          end
        end else if (i_halt_req) begin
          // Stop fetching; a word already at decode is still delivered.
          w_state_d = HALT;
        end else begin
          // Only issue when the memory output slot is free or being drained,
          // otherwise the held word would be overwritten.
          w_issue = ~r_valid_q | i_id_ready;
        end
      end
      HALT, FAULT: begin
        if (i_redirect_valid) begin
          if (w_misalign) begin
            w_state_d = FAULT;
          end else begin
            w_issue   = 1'b1;
            w_state_d = RUN;
          end
        end
      end
      default: begin
        w_state_d = BOOT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // PC, in-flight PC, valid and state registers
  // --------------------------------------------------------------------------
  // Advance the PC on issue and track whether a fetched word awaits decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q   <= BOOT;
      r_pc_q      <= RESET_PC;
      r_inst_pc_q <= RESET_PC;
      r_valid_q   <= 1'b0;
    end else begin
      r_state_q <= w_state_d;
      if (w_issue) begin
        r_pc_q      <= pc_next_seq(w_fa);
        r_inst_pc_q <= w_fa;
        r_valid_q   <= 1'b1;
      end else if (w_misalign) begin
        // The held word belongs to the abandoned path.
        r_valid_q <= 1'b0;
      end else begin
        r_valid_q <= r_valid_q & ~i_id_ready;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Trap reporting
  // --------------------------------------------------------------------------
`ifdef IF_FETCH_MISALIGN_TRAP_EN
  logic [XLEN-1:0] r_fault_pc;

  // Capture the offending target; clear once an aligned redirect recovers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fault_pc <= '0;
    end else if (w_misalign) begin
      r_fault_pc <= i_redirect_pc;
    end else if (w_issue && (r_state_q == FAULT)) begin
      r_fault_pc <= '0;
    end
  end

  assign o_fetch_fault = (r_state_q == FAULT);
  assign o_fault_pc    = r_fault_pc;
`else
  assign o_fetch_fault = 1'b0;
  assign o_fault_pc    = '0;
`endif

  // --------------------------------------------------------------------------
  // Decode interface
  // --------------------------------------------------------------------------
  // A word sitting at decode during a redirect is from the wrong path and is
  // squashed combinationally.
  assign o_id_valid = r_valid_q & ~i_redirect_valid;
  assign o_id_inst  = i_imem_rdata;
  assign o_id_pc    = r_inst_pc_q;

endmodule
`default_nettype wire

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the RV32I core. Owns the program counter, drives the synchronous instruction memory (one-cycle read latency, registered output that holds while its enable is low), and presents fetched instructions with their PC to decode over a valid/ready handshake. Accepts redirects from execute, halt requests from control, and optionally traps misaligned redirect targets.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `IMEM_AW`, default 12: instruction memory word-address width. Byte PC bits [IMEM_AW+1:2] form the address.
- `clk` in 1: core clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `imem_en` out 1: instruction memory enable; high means a fetch is issued this cycle.
- `imem_we` out 4: byte write enables; constant 0.
- `imem_wdata` out 32: constant 0.
- `imem_adr` out IMEM_AW: word address of the fetch.
- `imem_rdata` in 32: memory read data, valid the cycle after an issue.
- `redirect_valid` in 1: execute requests fetch from `redirect_pc`.
- `redirect_pc` in 32: redirect target byte address.
- `halt_req` in 1: control requests fetch stop (ecall/ebreak/wfi).
- `id_valid` out 1: instruction available to decode.
- `id_ready` in 1: decode accepts this cycle.
- `id_inst` out 32: instruction, equal to `imem_rdata`.
- `id_pc` out 32: byte PC of `id_inst`.
- `fetch_fault` out 1: misaligned redirect trap pending (macro-dependent).
- `fault_pc` out 32: offending target.

## Operation
- Registers: `pc_q` (next fetch address), `inst_pc_q` (PC of in-flight/held word), `valid_q`, `state_q`.
- States:
  - BOOT: first cycle after reset, no issue; moves to RUN.
  - RUN: normal fetching.
  - HALT: no fetch until a redirect.
  - FAULT: no fetch until an aligned redirect; present only with the macro.
- Fetch address `fa` = `redirect_pc` if `redirect_valid`, else `pc_q`. `imem_adr` = `fa[IMEM_AW+1:2]` at all times.
- Issue (`imem_en`=1) conditions:
  - In RUN: `redirect_valid` or (`!halt_req` and (`!valid_q` or `id_ready`)).
  - In HALT/FAULT: `redirect_valid` only (FAULT: also requires the target to be aligned).
  - In BOOT: never.
- On issue: `pc_q` <= `fa`+4, with 32-bit wrap. `inst_pc_q` <= `fa`. `valid_q` <= 1.
- No issue: `valid_q` <= `valid_q` & ~`id_ready`. Memory output holds because `imem_en`=0, so a stalled word stays stable.
- `id_valid` = `valid_q` & ~`redirect_valid`. A word is combinationally squashed in a redirect cycle and is never handed over.
- `id_pc` = `inst_pc_q`.
- Halt: `halt_req` in RUN without a redirect suppresses the issue and moves to HALT. An already valid word is still delivered. Redirect in HALT issues and returns to RUN.
- Simultaneous `redirect_valid` and `halt_req`: the redirect wins, the state ends in RUN, and the halt is ignored.
- Memory wrap: addresses beyond 2^(IMEM_AW+2) bytes alias modulo memory size. `pc_q` keeps all 32 bits.

## Timing
- Reset values:
  - `imem_en`=0, `imem_adr`=RESET_PC[IMEM_AW+1:2], `imem_we`=0.
  - `id_valid`=0, `id_pc`=RESET_PC.
  - `fetch_fault`=0, `fault_pc`=0.
  - State BOOT.
- Reset asserted mid-operation clears state immediately. An in-flight word is discarded.
- Fetch latency: issue in cycle N, so `id_valid`=1 with `id_inst` in cycle N+1.
- Throughput: one instruction per cycle while `id_ready`=1.
- First issue occurs the cycle after BOOT, with RESET_PC visible at `id_*` one cycle later.
- Redirect latency: target issued in the redirect cycle, so the target word is at decode the next cycle. This is a one-bubble penalty.
- Stall: while `id_valid` & ~`id_ready`, `id_inst` and `id_pc` are held bit-stable.

## Configuration
- `IF_FETCH_MISALIGN_TRAP_EN` defined:
  - A redirect with `redirect_pc[1:0]`!=0 issues nothing.
  - `valid_q` clears and the state moves to FAULT.
  - `fetch_fault`=1 and `fault_pc`=`redirect_pc` from the next cycle, held until an aligned redirect, which issues and returns to RUN.
- Undefined:
  - `redirect_pc[1:0]` are ignored (forced 0 into `pc_q`/`inst_pc_q`).
  - FAULT state is absent.
  - `fetch_fault` and `fault_pc` are tied 0.

## Structure
- Shared package `rv32i_pkg` holds:
  - `fetch_state_t` enum (BOOT, RUN, HALT, FAULT).
  - `RESET_PC_DEFAULT`.
  - `IMEM_AW_DEFAULT`.
  - `XLEN`=32.
- Single module, no sub-module; the PC/issue logic is too small to split.

## Test plan
- Reset release, `id_ready`=1, memory holding 0x00000013 at words 0..3:
  - `imem_en` rises the cycle after BOOT.
  - `id_pc` sequence is 0x0, 0x4, 0x8, one per cycle.
- `id_ready`=0 for 3 cycles with a valid word at 0x8:
  - `imem_en`=0.
  - `id_inst` and `id_pc`=0x8 are held.
  - 0xC is delivered the cycle after `id_ready` returns.
- `redirect_valid` with `redirect_pc`=0x100 while 0x10 is valid:
  - `id_valid`=0 that cycle and `imem_adr`=0x40.
  - `id_pc`=0x100 on the next cycle.
- `halt_req` pulse:
  - Fetch stops and the pending word is delivered.
  - Redirect to 0x200 resumes with `id_pc`=0x200.
  - Simultaneous halt and redirect lands in RUN.
- With `IF_FETCH_MISALIGN_TRAP_EN`, redirect to 0x102:
  - `fetch_fault`=1 and `fault_pc`=0x102, with no issue.
  - Redirect to 0x104 clears the fault and fetches 0x104.
  - Without the macro, 0x102 fetches 0x100.
- `rst` asserted mid-stream:
  - All outputs return to reset values asynchronously.
  - Refetch restarts at RESET_PC.
